// File: rtl/ffnn_neuron_mac_sequencer.sv
// Fully-connected layer sequencer: reads x, weights and bias over Avalon-MM,
// multiply-accumulates in fixed point, saturates, optional ReLU, writes y back.
module ffnn_neuron_mac_sequencer #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int ACC_W     = 48,
  parameter int RELU      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [ADDR_W-1:0] num_inputs,
  input  logic [ADDR_W-1:0] num_neurons,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_X, S_FETCH_W, S_ACC, S_FETCH_B, S_ADD_B, S_WRITE, S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_in_base, r_out_base, r_num_in, r_num_neu;
  logic [ADDR_W-1:0]   r_i, r_n, r_w_ptr;
  logic [DATA_W-1:0]   r_x;
  logic [ACC_W-1:0]    r_acc;

  logic signed [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_term, w_bias_ext;
  logic [ADDR_W-1:0]   w_last_i, w_last_n;
  logic                w_in_range;
  logic [DATA_W-1:0]   w_sat, w_result;

  assign w_prod     = $signed(r_x) * $signed(mem_readdata);
  assign w_term     = ACC_W'(w_prod >>> FRAC_BITS);
  assign w_bias_ext = {{(ACC_W-DATA_W){mem_readdata[DATA_W-1]}}, mem_readdata};
  assign w_last_i   = r_num_in - {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_last_n   = r_num_neu - {{(ADDR_W-1){1'b0}}, 1'b1};

  // In range when every bit from the DATA_W sign bit upward agrees.
  assign w_in_range = (&r_acc[ACC_W-1:DATA_W-1]) | ~(|r_acc[ACC_W-1:DATA_W-1]);
  assign w_sat      = w_in_range ? r_acc[DATA_W-1:0] :
                      (r_acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
  assign w_result   = ((RELU != 0) && w_sat[DATA_W-1]) ? '0 : w_sat;

  assign mem_byteenable = 4'hF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    busy           = 1'b0;
    done           = 1'b0;
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_neurons == '0)     w_next = S_DONE;
          else if (num_inputs == '0) w_next = S_FETCH_B;
          else                       w_next = S_FETCH_X;
        end
      end
      S_FETCH_X: begin
        busy           = 1'b1;
        mem_address    = r_in_base + r_i;
        mem_chipselect = 1'b1;
        w_next         = S_FETCH_W;
      end
      S_FETCH_W: begin
        busy           = 1'b1;
        mem_address    = r_w_ptr;
        mem_chipselect = 1'b1;
        w_next         = S_ACC;
      end
      S_ACC: begin
        busy   = 1'b1;
        w_next = (r_i == w_last_i) ? S_FETCH_B : S_FETCH_X;
      end
      S_FETCH_B: begin
        busy           = 1'b1;
        mem_address    = r_w_ptr;
        mem_chipselect = 1'b1;
        w_next         = S_ADD_B;
      end
      S_ADD_B: begin
        busy   = 1'b1;
        w_next = S_WRITE;
      end
      S_WRITE: begin
        busy           = 1'b1;
        mem_address    = r_out_base + r_n;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_writedata  = w_result;
        if (r_n == w_last_n)      w_next = S_DONE;
        else if (r_num_in == '0)  w_next = S_FETCH_B;
        else                      w_next = S_FETCH_X;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_base  <= '0;
      r_out_base <= '0;
      r_num_in   <= '0;
      r_num_neu  <= '0;
      r_i        <= '0;
      r_n        <= '0;
      r_w_ptr    <= '0;
      r_x        <= '0;
      r_acc      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_in_base  <= in_base;
            r_out_base <= out_base;
            r_num_in   <= num_inputs;
            r_num_neu  <= num_neurons;
            r_w_ptr    <= w_base;
            r_i        <= '0;
            r_n        <= '0;
            r_acc      <= '0;
          end
        end
        S_FETCH_W: r_x <= mem_readdata;
        S_ACC: begin
          r_acc   <= r_acc + w_term;
          r_i     <= r_i + 1'b1;
          r_w_ptr <= r_w_ptr + 1'b1;
        end
        S_ADD_B: r_acc <= r_acc + w_bias_ext;
        S_WRITE: begin
          // Stepping past the bias lands on the next neuron's first weight.
          if (r_n != w_last_n) begin
            r_n     <= r_n + 1'b1;
            r_i     <= '0;
            r_acc   <= '0;
            r_w_ptr <= r_w_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ffnn_neuron_mac_sequencer.sv
// Directed bench: two DUTs (ReLU on / off) each with its own memory model;
// expected writes are queued by the stimulus and checked by a write monitor.
module tb_ffnn_neuron_mac_sequencer;
  localparam int AW = 13;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start0, start1;
  logic [AW-1:0] in_base, w_base, out_base, num_inputs, num_neurons;

  logic          busy0, done0, cs0, wr0;
  logic [AW-1:0] addr0;
  logic [3:0]    be0;
  logic [DW-1:0] wd0;
  logic [DW-1:0] rd0 = '0;
  logic          busy1, done1, cs1, wr1;
  logic [AW-1:0] addr1;
  logic [3:0]    be1;
  logic [DW-1:0] wd1;
  logic [DW-1:0] rd1 = '0;

  logic [DW-1:0] mem0 [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];

  ffnn_neuron_mac_sequencer #(.RELU(1)) dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .in_base(in_base), .w_base(w_base), .out_base(out_base),
    .num_inputs(num_inputs), .num_neurons(num_neurons),
    .busy(busy0), .done(done0), .mem_address(addr0), .mem_chipselect(cs0),
    .mem_write(wr0), .mem_byteenable(be0), .mem_writedata(wd0), .mem_readdata(rd0));

  ffnn_neuron_mac_sequencer #(.RELU(0)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .in_base(in_base), .w_base(w_base), .out_base(out_base),
    .num_inputs(num_inputs), .num_neurons(num_neurons),
    .busy(busy1), .done(done1), .mem_address(addr1), .mem_chipselect(cs1),
    .mem_write(wr1), .mem_byteenable(be1), .mem_writedata(wd1), .mem_readdata(rd1));

  always @(posedge clk) begin
    if (cs0 && !wr0) rd0 <= mem0[addr0];
    if (cs0 && wr0)  mem0[addr0] <= wd0;
    if (cs1 && !wr1) rd1 <= mem1[addr1];
    if (cs1 && wr1)  mem1[addr1] <= wd1;
  end

  logic [44:0] q0[$];
  logic [44:0] q1[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt0 = 0;
  int cs_cnt0 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_write(input int d, input logic [3:0] be, input logic [AW-1:0] a,
                           input logic [DW-1:0] dat);
    logic [44:0] e;
    n_vec++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_err++;
      $display("FAIL wr%0d_unexpected: got addr=%h data=%h expected no write", d, a, dat);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      if ({be, a, dat} !== {4'hF, e}) begin
        n_err++;
        $display("FAIL wr%0d: got be=%h addr=%h data=%h expected be=f addr=%h data=%h",
                 d, be, a, dat, e[44:32], e[31:0]);
      end
    end
  endtask

  // Write monitor: decoupled from stimulus, pops one expectation per write strobe.
  always @(negedge clk) begin
    if (!reset) begin
      if (done0) done_cnt0++;
      if (cs0) cs_cnt0++;
      if (cs0 && wr0) chk_write(0, be0, addr0, wd0);
      if (cs1 && wr1) chk_write(1, be1, addr1, wd1);
    end
  end

  task automatic run(input int d, input logic [AW-1:0] ib, input logic [AW-1:0] wb,
                     input logic [AW-1:0] ob, input logic [AW-1:0] n, input logic [AW-1:0] m,
                     input int exp_cyc, input int glitch);
    int cyc;
    int busy_hi;
    in_base = ib; w_base = wb; out_base = ob; num_inputs = n; num_neurons = m;
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    cyc = 1;
    busy_hi = 0;
    while (!((d == 0) ? done0 : done1) && cyc < 300) begin
      if ((d == 0) ? busy0 : busy1) busy_hi++;
      if (cyc == glitch) begin
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        in_base = 13'h500; w_base = 13'h600; out_base = 13'h700;
        num_inputs = 13'd3; num_neurons = 13'd3;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start0 = 1'b0; start1 = 1'b0;
    chk($sformatf("done_latency_d%0d", d), 64'(cyc), 64'(exp_cyc));
    chk($sformatf("busy_at_done_d%0d", d), {63'd0, (d == 0) ? busy0 : busy1}, 64'd0);
    chk($sformatf("busy_cycles_d%0d", d), 64'(busy_hi), 64'(exp_cyc - 1));
    @(posedge clk); #1;
  endtask

  int dc;
  int cs_snap;

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    in_base = '0; w_base = '0; out_base = '0; num_inputs = '0; num_neurons = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_d0", {busy0, done0, cs0, wr0, be0, addr0, wd0}, {4'b0000, 4'hF, 13'h0, 32'h0});
    chk("reset_outs_d1", {busy1, done1, cs1, wr1, be1, addr1, wd1}, {4'b0000, 4'hF, 13'h0, 32'h0});
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // T1: 1*0.5 + 2*0.25 + 1.0 = 2.0
    mem0[13'h100] = 32'h0001_0000; mem0[13'h101] = 32'h0002_0000;
    mem0[13'h200] = 32'h0000_8000; mem0[13'h201] = 32'h0000_4000; mem0[13'h202] = 32'h0001_0000;
    q0.push_back({13'h300, 32'h0002_0000});
    run(0, 13'h100, 13'h200, 13'h300, 13'd2, 13'd1, 10, 0);

    // T2: ReLU clamps -1.0 to 0; second neuron 3.0 - 1.0
    mem0[13'h110] = 32'h0001_0000;
    mem0[13'h210] = 32'hFFFF_0000; mem0[13'h211] = 32'h0;
    mem0[13'h212] = 32'h0003_0000; mem0[13'h213] = 32'hFFFF_0000;
    q0.push_back({13'h310, 32'h0000_0000});
    q0.push_back({13'h311, 32'h0002_0000});
    run(0, 13'h110, 13'h210, 13'h310, 13'd1, 13'd2, 13, 0);

    // T3: N=0 passes the bias straight through
    mem0[13'h220] = 32'h0005_0000;
    q0.push_back({13'h320, 32'h0005_0000});
    run(0, 13'h100, 13'h220, 13'h320, 13'd0, 13'd1, 4, 0);

    // T4: M=0 touches no memory
    cs_snap = cs_cnt0;
    run(0, 13'h100, 13'h200, 13'h340, 13'd2, 13'd0, 1, 0);
    chk("m0_no_chipselect", 64'(cs_cnt0 - cs_snap), 64'd0);

    // T5: start pulsed mid-layer with different bases must be ignored
    mem0[13'h300] = 32'h0;
    dc = done_cnt0;
    q0.push_back({13'h300, 32'h0002_0000});
    run(0, 13'h100, 13'h200, 13'h300, 13'd2, 13'd1, 10, 3);
    repeat (5) @(posedge clk);
    #1;
    chk("single_done_pulse", 64'(done_cnt0 - dc), 64'd1);
    chk("idle_after_ignored_start", {63'd0, busy0}, 64'd0);

    // T6: reset during FETCH_W of neuron 1
    mem0[13'h120] = 32'h0001_0000;
    mem0[13'h230] = 32'h0002_0000; mem0[13'h231] = 32'h0;
    mem0[13'h232] = 32'h0003_0000; mem0[13'h233] = 32'h0;
    mem0[13'h330] = 32'hDEAD_BEEF; mem0[13'h331] = 32'hDEAD_BEEF;
    q0.push_back({13'h330, 32'h0002_0000});
    in_base = 13'h120; w_base = 13'h230; out_base = 13'h330; num_inputs = 13'd1; num_neurons = 13'd2;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    chk("fetch_w_n1_addr", {50'd0, cs0, addr0}, {50'd0, 1'b1, 13'h232});
    reset = 1'b1;
    #1;
    chk("async_reset_outs", {busy0, done0, cs0, wr0, be0, addr0, wd0}, {4'b0000, 4'hF, 13'h0, 32'h0});
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    chk("n0_kept_after_reset", {32'd0, mem0[13'h330]}, {32'd0, 32'h0002_0000});
    chk("n1_not_written", {32'd0, mem0[13'h331]}, {32'd0, 32'hDEAD_BEEF});
    chk("queue_drained_before_restart", 64'(q0.size()), 64'd0);
    @(posedge clk); #1;
    q0.push_back({13'h330, 32'h0002_0000});
    q0.push_back({13'h331, 32'h0003_0000});
    run(0, 13'h120, 13'h230, 13'h330, 13'd1, 13'd2, 13, 0);

    // Saturation on the linear-output instance
    mem1[13'h100] = 32'h7FFF_0000; mem1[13'h101] = 32'h7FFF_0000;
    mem1[13'h200] = 32'h7FFF_0000; mem1[13'h201] = 32'h7FFF_0000; mem1[13'h202] = 32'h0;
    mem1[13'h210] = 32'h7FFF_0000; mem1[13'h211] = 32'h8001_0000; mem1[13'h212] = 32'h0;
    mem1[13'h220] = 32'h8001_0000; mem1[13'h221] = 32'h8001_0000; mem1[13'h222] = 32'h0;
    q1.push_back({13'h300, 32'h7FFF_FFFF});
    run(1, 13'h100, 13'h200, 13'h300, 13'd2, 13'd1, 10, 0);
    q1.push_back({13'h301, 32'h0000_0000});
    run(1, 13'h100, 13'h210, 13'h301, 13'd2, 13'd1, 10, 0);
    q1.push_back({13'h302, 32'h8000_0000});
    run(1, 13'h100, 13'h220, 13'h302, 13'd2, 13'd1, 10, 0);

    // Address wrap on both weight pointer and output pointer; negative kept when linear
    mem1[13'h1FFF] = 32'h0001_0000; mem1[13'h0000] = 32'hFFFF_0000;
    q1.push_back({13'h1FFF, 32'h0001_0000});
    q1.push_back({13'h0000, 32'hFFFF_0000});
    run(1, 13'h100, 13'h1FFF, 13'h1FFF, 13'd0, 13'd2, 7, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ffnn_neuron_mac_sequencer.md
Name: ffnn_neuron_mac_sequencer

Overview:
- Avalon-MM master that sits directly upstream of the layer's single-port on-chip memory: 32-bit words, 13-bit word address, 1-cycle read latency.
- Computes one fully-connected layer in Q(32-FRAC_BITS).FRAC_BITS fixed point. For each neuron it reads inputs, weights and bias, multiply-accumulates, saturates, optionally applies ReLU, and writes the activation back to the same memory.
- Started and monitored by the layer controller through a start/busy/done handshake.

Parameters:
- ADDR_W, 13, memory word-address width; address arithmetic is modulo 2^ADDR_W.
- DATA_W, 32, memory data width and activation width.
- FRAC_BITS, 16, fractional bits of the fixed-point format.
- ACC_W, 48, signed accumulator width.
- RELU, 1, 1 = clamp negative outputs to 0; 0 = linear output.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- in_base  in  ADDR_W  word address of input vector x[0..N-1].
- w_base  in  ADDR_W  weight block base; neuron n occupies w_base+n*(N+1): N weights, then the bias.
- out_base  in  ADDR_W  output y[n] is written at out_base+n.
- num_inputs  in  ADDR_W  N.
- num_neurons  in  ADDR_W  M.
- busy  out  1  high while a layer is in progress.
- done  out  1  one-cycle completion pulse.
- mem_address  out  ADDR_W  memory word address.
- mem_chipselect  out  1  memory access strobe.
- mem_write  out  1  write qualifier.
- mem_byteenable  out  4  always 4'hF.
- mem_writedata  out  DATA_W  result word.
- mem_readdata  in  DATA_W  valid the cycle after an address is presented with chipselect=1, write=0.

Behaviour:
- Reset values: busy=0, done=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=4'hF. State=IDLE, accumulator=0, counters=0.
- Reset mid-operation aborts immediately. Completed writes stay in memory; no partial write is issued.
- Start: start=1 in IDLE latches all base/count inputs, sets busy the next cycle and enters FETCH_X. start is ignored in every other state. Base/count inputs may change after the latch without effect.
- M=0: go IDLE -> DONE. No memory access.
- N=0 (and M>0): every neuron goes straight to FETCH_B, so its output equals the saturated/ReLU'd bias.
- FETCH_X: address=in_base+i, chipselect=1, write=0. Next state FETCH_W.
- FETCH_W: x_reg<=mem_readdata; address=w_ptr, chipselect=1. Next state ACC.
- ACC: chipselect=0. acc += sign-extend-to-ACC_W( (signed x_reg * signed mem_readdata) >>> FRAC_BITS ). The shift is arithmetic on the full 64-bit product; the accumulation wraps at ACC_W. Then i++, w_ptr++. Next state is FETCH_B if i==N-1, else FETCH_X.
- FETCH_B: address=w_ptr (the bias), chipselect=1. Next state ADD_B.
- ADD_B: acc += sign-extended mem_readdata. Next state WRITE.
- WRITE: r = acc saturated to the signed DATA_W range [0x80000000, 0x7FFFFFFF]. If RELU and r<0, r=0. Drive address=out_base+n, writedata=r, chipselect=1, write=1 for exactly one cycle.
  - If n==M-1: next state DONE.
  - Otherwise: n++, acc=0, i=0, w_ptr++ (now pointing at the next neuron's first weight), next state FETCH_X (or FETCH_B if N=0).
- DONE: done=1 for one cycle, busy=0 in that same cycle, then IDLE. A start arriving in the cycle after DONE is accepted.
- Timing: cycles from the start-sample edge to done = 1 + M*(3N+3). Memory strobes occur only in FETCH_X, FETCH_W, FETCH_B and WRITE.
- Wrap: address sums truncate to ADDR_W bits. No error is flagged.

Test Plan:
- N=2, M=1; x=[0x00010000, 0x00020000], w=[0x00008000, 0x00004000], bias=0x00010000 -> single write of 0x00020000 at out_base; done 10 cycles after start; busy high for cycles 1-9.
- N=1, M=2, RELU=1; x=[0x00010000]; neuron0 w=0xFFFF0000 (-1.0), bias=0; neuron1 w=0x00030000, bias=0xFFFF0000 -> out_base=0x00000000, out_base+1=0x00020000; neuron1 weight read at w_base+2.
- Saturation: N=2, x=[0x7FFF0000, 0x7FFF0000], w=[0x7FFF0000, 0x7FFF0000], bias=0 -> 0x7FFFFFFF. Same with one weight negated and RELU=0 -> 0x00000000 (exact cancel). Both weights negated -> 0x80000000.
- Degenerate counts: N=0, M=1, bias=0x00050000 -> 0x00050000 written, done 4 cycles after start. M=0 -> done 1 cycle after start, chipselect never asserted.
- Reset asserted asynchronously during the FETCH_W of neuron 1 -> all outputs return to reset values within the same cycle; neuron0's result remains in memory; a new start runs the layer cleanly to completion.
- start pulsed while busy with different bases -> ignored; all accesses use the originally latched bases; done is pulsed exactly once.
